button_event_ctrl: RTL
======================

Name: button_event_ctrl

Overview:
- Turns debounced, synchronized button levels into classified events: short press, long press, and auto-repeat.
- Shares a single event output channel between N_BTN buttons using round-robin arbitration and a valid/ready handshake.
- Sits between the per-button debounce/sync blocks and the bench's mode/menu logic.
- Timing comes from a one-cycle `tick` strobe derived from the clock divider.

Parameters:
- N_BTN, 4, number of buttons; range 2..8.
- LONG_TICKS, 8, ticks held before a LONG event is emitted; must be ≥2.
- REPEAT_TICKS, 4, ticks between REPEAT events after LONG; must be ≥1.
- CNT_W, 4, hold-counter width; must satisfy 2^CNT_W ≥ max(LONG_TICKS, REPEAT_TICKS).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-clk strobe from the divider; hold timebase.
- btn  in  N_BTN  debounced, synchronized button levels; 1 = pressed.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event.
- ev_btn  out  IDX_W  button index, where IDX_W = max(1, clog2(N_BTN)).
- ev_kind  out  2  event kind: 0 SHORT, 1 LONG, 2 REPEAT; 3 is never produced.
- ovf  out  1  sticky flag: an event was dropped.
- ovf_clr  in  1  clears ovf.

Behaviour:
Reset
- All of the following are asynchronous on rst_n=0: ev_valid=0, ev_btn=0, ev_kind=0, ovf=0.
- All per-button FSMs go to IDLE; all pending slots are empty; counters are 0; round-robin pointer is 0.
- Reset asserted mid-press: the press is forgotten. If btn is still 1 after reset release, the FSM goes to HELD with cnt=0 on the first edge.

Per-button FSM (three states, counter cnt)
- IDLE: btn=1 → HELD, cnt=0.
- HELD:
  - btn=0 → emit SHORT, go to IDLE.
  - Else on tick: if cnt==LONG_TICKS-1, emit LONG, go to LONG_HELD, cnt=0; otherwise cnt+1.
- LONG_HELD:
  - btn=0 → IDLE, no event.
  - Else on tick: if cnt==REPEAT_TICKS-1, emit REPEAT and set cnt=0; otherwise cnt+1.
- Release and tick in the same cycle: release wins.
- Ticks are counted only while the button is held. Maximum SHORT-hold latency ambiguity is one tick period.

Pending slot (one per button)
- Holds kind plus a valid bit; it is written the cycle after event detection.
- New event while the slot is occupied and not being granted this cycle: the new event is dropped and ovf is set.
- New event in the same cycle the slot is granted: the new event is stored, no overflow.
- ovf_clr and a drop in the same cycle: ovf stays 1 (set wins).

Arbiter / output register
- The output register loads when ev_valid=0, or when ev_valid & ev_ready (back-to-back transfers allowed, one per cycle).
- Grant goes to the first pending slot at or after ptr, wrapping modulo N_BTN. The granted slot clears.
- After a grant, ptr = granted index + 1, with wrap.
- While ev_valid=1 and ev_ready=0, ev_btn and ev_kind are held stable.
- Latency: btn edge at cycle t → FSM sees it at t → slot valid at t+1 → ev_valid at t+2 (output empty, no contention).
- No pending slots and output popped → ev_valid=0 next cycle.

Optional Feature:
BTN_REPEAT_EN
- Defined: REPEAT events are generated in LONG_HELD as described above.
- Undefined:
  - LONG_HELD emits nothing and cnt is not implemented for that state.
  - ev_kind is never 2.
  - REPEAT_TICKS is ignored.

Decomposition:
- Package btn_pkg:
  - ev_kind_t enum (EV_SHORT=2'd0, EV_LONG=2'd1, EV_REPEAT=2'd2).
  - Per-button state enum (ST_IDLE, ST_HELD, ST_LONG).
- Sub-module btn_classifier: one per button, generated N_BTN times.
  - Contains the FSM and counter.
  - Outputs a one-cycle ev_stb and ev_kind.
- Top level contains the pending slots, round-robin arbiter, output register, and ovf.

Test Plan:
1. Short press: btn[0]=1 for 3 ticks, then 0 → one event ev_btn=0, ev_kind=0, ev_valid 2 clks after release, with ev_ready=1.
2. Long press and repeat (BTN_REPEAT_EN): btn[1] held 8+4+4 ticks → LONG at tick 8, REPEAT at ticks 12 and 16; release gives no further event.
3. Round-robin: btn[0], btn[2], btn[3] released in the same cycle, ptr=0, ev_ready=1 → SHORT events for 0, 2, 3 on consecutive cycles; ptr=0 afterwards. Repeat with ptr=3 → order 3, 0, 2.
4. Backpressure and overflow: ev_ready=0, btn[1] short pressed twice → first event held stable on the output; second event in the pending slot. A third press → dropped, ovf=1; ovf_clr pulse → ovf=0.
5. Reset mid-operation: rst_n low during HELD with an event pending and ev_valid=1 → all outputs 0 immediately; after release with btn still 1, no spurious SHORT; LONG after LONG_TICKS ticks.
6. Release and tick in the same cycle at cnt=LONG_TICKS-1 → SHORT emitted, not LONG.

Source files
------------

// File: rtl/button_event_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types for the button event controller.
//   ev_kind_t  : event classification carried on the output channel
//   btn_state_t: per-button classifier state
// Optional feature macro used by the files that import this package:
//   BTN_REPEAT_EN - enables REPEAT events while a button stays long-held.
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        EV_SHORT  = 2'd0,
        EV_LONG   = 2'd1,
        EV_REPEAT = 2'd2
    } ev_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } btn_state_t;

    // Index width for a given button count; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_event_ctrl_classifier.sv
// -----------------------------------------------------------------------------
// btn_classifier
// Classifies one debounced button into SHORT / LONG / REPEAT events using a
// tick-driven hold counter. The event strobe is combinational (Mealy) so the
// parent can latch it into its pending slot on the same edge the FSM moves.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick        : one-cycle timebase strobe
//   btn         : button level, 1 = pressed
//   ev_stb      : one-cycle event strobe
//   ev_kind     : kind of the event flagged by ev_stb
// Macro: BTN_REPEAT_EN - REPEAT events in the long-held state.
// -----------------------------------------------------------------------------
module btn_classifier
    import btn_pkg::*;
#(
    parameter int LONG_TICKS   = 8,
    parameter int REPEAT_TICKS = 4,
    parameter int CNT_W        = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     tick,
    input  logic     btn,
    output logic     ev_stb,
    output ev_kind_t ev_kind
);

    // Elaboration-time parameter sanity.
    if (LONG_TICKS < 2) begin : g_bad_long
        $error("btn_classifier: LONG_TICKS must be >= 2");
    end
    if (REPEAT_TICKS < 1) begin : g_bad_repeat
        $error("btn_classifier: REPEAT_TICKS must be >= 1");
    end
    if ((2 ** CNT_W) < LONG_TICKS || (2 ** CNT_W) < REPEAT_TICKS) begin : g_bad_cnt
        $error("btn_classifier: CNT_W too narrow");
    end

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

    btn_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Release is tested before tick so a release coinciding with a tick
    // always wins.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ev_stb     = 1'b0;
        ev_kind    = EV_SHORT;
        case (state_reg)
            ST_IDLE: begin
                if (btn) begin
                    state_next = ST_HELD;
                    cnt_next   = '0;
                end
            end
            ST_HELD: begin
                if (!btn) begin
                    ev_stb     = 1'b1;
                    ev_kind    = EV_SHORT;
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (tick) begin
                    if (cnt_reg == LONG_LAST) begin
                        ev_stb     = 1'b1;
                        ev_kind    = EV_LONG;
                        state_next = ST_LONG;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_LONG: begin
                if (!btn) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
`ifdef BTN_REPEAT_EN
                else if (tick) begin
                    if (cnt_reg == REPEAT_LAST) begin
                        ev_stb   = 1'b1;
                        ev_kind  = EV_REPEAT;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_event_ctrl.sv
// -----------------------------------------------------------------------------
// button_event_ctrl
// Classifies N_BTN button levels into SHORT / LONG / REPEAT events and shares
// one valid/ready event channel between them through per-button pending
// slots and a round-robin arbiter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick        : hold timebase strobe
//   btn         : button levels, 1 = pressed
//   ev_valid    : event available
//   ev_ready    : consumer accepts the event
//   ev_btn      : index of the button that produced the event
//   ev_kind     : 0 SHORT, 1 LONG, 2 REPEAT
//   ovf         : sticky, set when an event had to be dropped
//   ovf_clr     : clears ovf (a simultaneous drop keeps it set)
// Macro: BTN_REPEAT_EN - enables REPEAT events (otherwise kind 2 never occurs).
// -----------------------------------------------------------------------------
module button_event_ctrl
    import btn_pkg::*;
#(
    parameter  int N_BTN        = 4,
    parameter  int LONG_TICKS   = 8,
    parameter  int REPEAT_TICKS = 4,
    parameter  int CNT_W        = 4,
    localparam int IDX_W        = idx_width(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_btn,
    output logic [1:0]       ev_kind,
    output logic             ovf,
    input  logic             ovf_clr
);

    if (N_BTN < 2 || N_BTN > 8) begin : g_bad_n
        $error("button_event_ctrl: N_BTN must be in 2..8");
    end

    // Classifier outputs
    logic [N_BTN-1:0] stb;
    ev_kind_t         stb_kind [N_BTN];

    // Pending slots
    logic [N_BTN-1:0] pend_valid_reg;
    ev_kind_t         pend_kind_reg [N_BTN];

    // Arbiter
    logic [IDX_W-1:0] ptr_reg;
    logic             load;
    logic             gnt_any;
    logic [IDX_W-1:0] gnt_idx;
    ev_kind_t         gnt_kind;
    logic [N_BTN-1:0] gnt_oh;
    logic [N_BTN-1:0] take;
    logic [N_BTN-1:0] drop;
    int               scan_idx;

    // Output register
    logic             ev_valid_reg;
    logic [IDX_W-1:0] ev_btn_reg;
    ev_kind_t         ev_kind_reg;
    logic             ovf_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            btn_classifier #(
                .LONG_TICKS   (LONG_TICKS),
                .REPEAT_TICKS (REPEAT_TICKS),
                .CNT_W        (CNT_W)
            ) u_cls (
                .clk     (clk),
                .rst_n   (rst_n),
                .tick    (tick),
                .btn     (btn[gi]),
                .ev_stb  (stb[gi]),
                .ev_kind (stb_kind[gi])
            );

            // A slot being handed to the output this cycle is free again,
            // so a new event on the same edge is kept rather than dropped.
            assign take[gi] = load & gnt_oh[gi];
            assign drop[gi] = stb[gi] & pend_valid_reg[gi] & ~take[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_valid_reg[gi] <= 1'b0;
                    pend_kind_reg[gi]  <= EV_SHORT;
                end else if (stb[gi] && !drop[gi]) begin
                    pend_valid_reg[gi] <= 1'b1;
                    pend_kind_reg[gi]  <= stb_kind[gi];
                end else if (take[gi]) begin
                    pend_valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Output accepts a new event when empty or when its current one is taken.
    assign load = ~ev_valid_reg | ev_ready;

    // Round-robin scan starting at ptr_reg, wrapping modulo N_BTN.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_kind = EV_SHORT;
        gnt_oh   = '0;
        scan_idx = 0;
        for (int off = 0; off < N_BTN; off++) begin
            scan_idx = (int'(ptr_reg) + off) % N_BTN;
            if (!gnt_any && pend_valid_reg[scan_idx]) begin
                gnt_any          = 1'b1;
                gnt_idx          = IDX_W'(scan_idx);
                gnt_kind         = pend_kind_reg[scan_idx];
                gnt_oh[scan_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid_reg <= 1'b0;
            ev_btn_reg   <= '0;
            ev_kind_reg  <= EV_SHORT;
            ptr_reg      <= '0;
        end else if (load) begin
            if (gnt_any) begin
                ev_valid_reg <= 1'b1;
                ev_btn_reg   <= gnt_idx;
                ev_kind_reg  <= gnt_kind;
                ptr_reg      <= (gnt_idx == IDX_W'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                ev_valid_reg <= 1'b0;
            end
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (|drop) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    assign ev_valid = ev_valid_reg;
    assign ev_btn   = ev_btn_reg;
    assign ev_kind  = ev_kind_reg;
    assign ovf      = ovf_reg;

endmodule
